// File: rtl/phy_pkg.sv
// Shared 802.11a PHY definitions: modulation encodings and per-modulation symbol geometry.
// The demapper uses the same encodings.
package phy_pkg;

  localparam int unsigned N_SC     = 48;
  localparam int unsigned MAX_BPSC = 6;

  typedef logic [1:0] mod_t;

  localparam mod_t MOD_BPSK  = 2'd0;
  localparam mod_t MOD_QPSK  = 2'd1;
  localparam mod_t MOD_QAM16 = 2'd2;
  localparam mod_t MOD_QAM64 = 2'd3;

  function automatic logic [2:0] n_bpsc(input mod_t m);
    logic [2:0] r;
    unique case (m)
      MOD_BPSK:  r = 3'd1;
      MOD_QPSK:  r = 3'd2;
      MOD_QAM16: r = 3'd4;
      default:   r = 3'd6;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] n_cbps(input mod_t m);
    logic [8:0] r;
    unique case (m)
      MOD_BPSK:  r = 9'd48;
      MOD_QPSK:  r = 9'd96;
      MOD_QAM16: r = 9'd192;
      default:   r = 9'd288;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] s_of(input mod_t m);
    logic [1:0] r;
    unique case (m)
      MOD_BPSK:  r = 2'd1;
      MOD_QPSK:  r = 2'd1;
      MOD_QAM16: r = 2'd2;
      default:   r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// Combinational deinterleaver address: output index k -> bank position j for a given modulation.
module deint_addr_gen
  import phy_pkg::*;
(
  input  logic [1:0] mod,
  input  logic [8:0] k,
  output logic [8:0] j
);

  logic [3:0] k_lo;
  logic [4:0] k_hi;
  logic [8:0] i12;
  logic [2:0] hi_q3, lo_q3;
  logic [1:0] hi_r3, lo_r3, rot;

  // Quotient by 3 for values below 18, built from comparators.
  function automatic logic [2:0] div3(input logic [4:0] v);
    logic [2:0] q;
    q = 3'd0;
    for (int t = 1; t < 6; t++) begin
      if (v >= 5'(3 * t)) q = 3'(t);
    end
    return q;
  endfunction

  // i = (N_CBPS/16)*(k%16) + k/16 with k/16 < N_CBPS/16, so i / (N_CBPS/16) is k%16 and
  // i % (N_CBPS/16) is k/16; the remaining divisions collapse onto k's nibbles.
  always_comb begin
    k_lo  = k[3:0];
    k_hi  = k[8:4];
    i12   = 9'(k_lo) * 9'd12 + 9'(k_hi);
    hi_q3 = div3(k_hi);
    lo_q3 = div3({1'b0, k_lo});
    hi_r3 = 2'(k_hi - 5'(hi_q3) * 5'd3);
    lo_r3 = 2'({1'b0, k_lo} - 5'(lo_q3) * 5'd3);
    rot   = (hi_r3 >= lo_r3) ? (hi_r3 - lo_r3) : (hi_r3 + 2'd3 - lo_r3);
    j     = '0;
    unique case (mod)
      MOD_BPSK:  j = 9'(k_lo) * 9'd3 + 9'(k_hi);
      MOD_QPSK:  j = 9'(k_lo) * 9'd6 + 9'(k_hi);
      MOD_QAM16: j = {i12[8:1], i12[0] ^ k_lo[0]};
      MOD_QAM64: j = 9'(k_lo) * 9'd18 + 9'(hi_q3) * 9'd3 + 9'(rot);
      default:   j = '0;
    endcase
  end

endmodule

// File: rtl/deinterleaver.sv
// 802.11a block deinterleaver: ping-pong symbol banks, subcarrier-wide write side and
// serial bit read side, both with valid/ready handshakes.
module deinterleaver
  import phy_pkg::*;
#(
  parameter int unsigned N_SC     = 48,
  parameter int unsigned MAX_BPSC = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BPSC-1:0] in_bits,
  input  logic [1:0]          mod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic [1:0]          out_mod,
  output logic                out_last
);

  localparam int unsigned BankW = N_SC * MAX_BPSC;

  logic [BankW-1:0] bank_q [2];
  mod_t             bank_mod_q [2];
  logic [1:0]       full_q, full_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  logic [5:0]       c_q, c_d;
  logic [8:0]       k_q, k_d;
  logic             in_ready_q;
  logic             out_valid_q, out_bit_q, out_last_q;
  mod_t             out_mod_q;

  logic             wr_fire, present;
  mod_t             wr_mod, rd_mod;
  logic [2:0]       wr_nb;
  logic [8:0]       wr_base, rd_j;

  assign wr_fire = in_valid & in_ready_q;
  // mod is only meaningful with subcarrier 0; later subcarriers use the bank's latched copy.
  assign wr_mod  = (c_q == '0) ? mod : bank_mod_q[wp_q];
  assign wr_nb   = n_bpsc(wr_mod);
  assign wr_base = 9'(c_q) * 9'(wr_nb);

  always_comb begin
    c_d     = c_q;
    wp_d    = wp_q;
    full_d  = full_q;
    rp_d    = rp_q;
    k_d     = k_q;
    present = 1'b0;
    if (wr_fire) begin
      if (c_q == 6'(N_SC - 1)) begin
        c_d          = '0;
        wp_d         = ~wp_q;
        full_d[wp_q] = 1'b1;
      end else begin
        c_d = c_q + 6'd1;
      end
    end
    if (!out_valid_q) begin
      if (full_q[rp_q]) begin
        present = 1'b1;
        k_d     = '0;
      end
    end else if (out_ready) begin
      if (out_last_q) begin
        full_d[rp_q] = 1'b0;
        rp_d         = ~rp_q;
        // Back-to-back symbols: present the next bank's k = 0 on the same edge.
        if (full_q[~rp_q]) begin
          present = 1'b1;
          k_d     = '0;
        end
      end else begin
        present = 1'b1;
        k_d     = k_q + 9'd1;
      end
    end
  end

  assign rd_mod = bank_mod_q[rp_d];

  deint_addr_gen u_addr_gen (
    .mod (rd_mod),
    .k   (k_d),
    .j   (rd_j)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < int'(MAX_BPSC); b++) begin
        if (b < int'(wr_nb)) bank_q[wp_q][wr_base + 9'(b)] <= in_bits[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q           <= '0;
      wp_q          <= 1'b0;
      rp_q          <= 1'b0;
      full_q        <= '0;
      k_q           <= '0;
      in_ready_q    <= 1'b0;
      bank_mod_q[0] <= MOD_BPSK;
      bank_mod_q[1] <= MOD_BPSK;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_mod_q     <= MOD_BPSK;
    end else begin
      c_q        <= c_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      full_q     <= full_d;
      k_q        <= k_d;
      in_ready_q <= ~full_d[wp_d];
      if (wr_fire && (c_q == '0)) bank_mod_q[wp_q] <= mod;
      if (present) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= bank_q[rp_d][rd_j];
        out_last_q  <= (k_d == n_cbps(rd_mod) - 9'd1);
        out_mod_q   <= rd_mod;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign out_mod   = out_mod_q;

endmodule

// File: tb/tb_deinterleaver.sv
// Directed and randomized bench for the deinterleaver against an arithmetic reference model.
module tb_deinterleaver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_bits;
  logic [1:0] mod;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [1:0] out_mod;
  logic       out_last;

  deinterleaver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_mod   (out_mod),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         got_bit[$];
  bit         got_last[$];
  logic [1:0] got_mod[$];
  int         got_cyc[$];

  // Record every output transfer; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_bit.push_back(out_bit);
      got_last.push_back(out_last);
      got_mod.push_back(out_mod);
      got_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbpsc(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
  endfunction

  function automatic int ref_j(input int nb, input int k);
    int ncbps, s, i;
    ncbps = 48 * nb;
    s     = (nb / 2 > 1) ? nb / 2 : 1;
    i     = (ncbps / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
  endfunction

  function automatic logic [287:0] rand_sym();
    logic [287:0] r;
    r = '0;
    for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [287:0] onehot(input int j);
    logic [287:0] r;
    r    = '0;
    r[j] = 1'b1;
    return r;
  endfunction

  function automatic int first_one(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (base + k < got_bit.size() && got_bit[base+k]) return k;
    end
    return -1;
  endfunction

  task automatic send(input int m, input logic [287:0] sym, input int nc);
    int nb, t;
    logic acc;
    logic [5:0] v;
    nb = nbpsc(m);
    for (int c = 0; c < nc; c++) begin
      v = 6'($urandom);
      for (int b = 0; b < nb; b++) v[b] = sym[c*nb+b];
      in_bits  = v;
      mod      = (c == 0) ? 2'(m) : 2'($urandom);
      in_valid = 1'b1;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 3000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        in_valid = 1'b0;
        check("send_timeout", 288'(acc), 288'(1));
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd);
    int t;
    t = 0;
    while (got_bit.size() < n && t < 5000) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom);
      t++;
    end
    out_ready = 1'b1;
    check("collect_timeout", 288'(got_bit.size() >= n), 288'(1));
  endtask

  task automatic check_sym(input string tag, input int m, input logic [287:0] sym, input int base);
    int nb, ncb, bad;
    logic [287:0] gb, eb, gl, el;
    nb = nbpsc(m);
    ncb = 48 * nb;
    gb = '0; eb = '0; gl = '0; el = '0;
    bad = 0;
    for (int k = 0; k < ncb; k++) begin
      if (base + k < got_bit.size()) begin
        gb[k] = got_bit[base+k];
        gl[k] = got_last[base+k];
        if (int'(got_mod[base+k]) != m) bad++;
      end else begin
        bad++;
      end
      eb[k] = sym[ref_j(nb, k)];
    end
    el[ncb-1] = 1'b1;
    check({tag, "_bits"}, gb, eb);
    check({tag, "_last"}, gl, el);
    check({tag, "_mod_errs"}, 288'(bad), 288'(0));
  endtask

  task automatic run_sym(input string tag, input int m, input logic [287:0] sym, input bit rnd,
                         output int base);
    int ncb;
    ncb  = 48 * nbpsc(m);
    base = got_bit.size();
    send(m, sym, 48);
    collect(base + ncb, rnd);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 288'(got_bit.size() - base), 288'(ncb));
    check_sym(tag, m, sym, base);
  endtask

  initial begin
    int base;
    logic [287:0] s1, s2, s3, snap;

    rst_n = 1'b0; in_valid = 1'b0; in_bits = '0; mod = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 288'({out_valid, out_bit, out_last, out_mod}), 288'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 288'(in_ready), 288'(1));

    // One-hot positions whose output index is fixed by the interleaver definition.
    run_sym("bpsk_j3", 0, onehot(3), 1'b0, base);
    check("bpsk_j3_k", 288'(first_one(base, 48)), 288'(1));
    run_sym("bpsk_j1", 0, onehot(1), 1'b1, base);
    check("bpsk_j1_k", 288'(first_one(base, 48)), 288'(16));
    run_sym("qpsk_j6", 1, onehot(6), 1'b0, base);
    check("qpsk_j6_k", 288'(first_one(base, 96)), 288'(1));
    run_sym("qam16_j13", 2, onehot(13), 1'b0, base);
    check("qam16_j13_k", 288'(first_one(base, 192)), 288'(1));
    run_sym("qam16_j0", 2, onehot(0), 1'b1, base);
    check("qam16_j0_k", 288'(first_one(base, 192)), 288'(0));
    run_sym("qam64_j20", 3, onehot(20), 1'b0, base);
    check("qam64_j20_k", 288'(first_one(base, 288)), 288'(1));
    for (int m = 0; m < 4; m++) run_sym("rand", m, rand_sym(), 1'b1, base);
    run_sym("qam64_rand", 3, rand_sym(), 1'b0, base);

    // Ping-pong with downstream stalled: both banks fill, input must stall.
    s1 = rand_sym(); s2 = rand_sym(); s3 = rand_sym();
    base = got_bit.size();
    out_ready = 1'b0;
    send(3, s1, 48);
    repeat (2) @(posedge clk);
    #1;
    check("pp_valid_stalled", 288'(out_valid), 288'(1));
    snap = 288'({out_valid, out_bit, out_last, out_mod});
    send(0, s2, 48);
    while (cyc < got_cyc.size() + 0 + 100 + (cyc - cyc) && cyc < 100000) begin
      @(negedge clk);
      check("pp_stable", 288'({out_valid, out_bit, out_last, out_mod}), snap);
      if (cyc >= 2 * 48 + 102 + got_cyc.size() * 0 + base * 0) break;
    end
    @(negedge clk);
    check("pp_stable_end", 288'({out_valid, out_bit, out_last, out_mod}), snap);
    check("pp_in_ready_full", 288'(in_ready), 288'(0));
    check("pp_no_xfer", 288'(got_bit.size() - base), 288'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1, s3, 48);
    collect(base + 288 + 48 + 96, 1'b0);
    check_sym("pp_s1", 3, s1, base);
    check_sym("pp_s2", 0, s2, base + 288);
    check_sym("pp_s3", 1, s3, base + 336);
    check("pp_no_bubble", 288'(got_cyc[base+288] - got_cyc[base+287]), 288'(1));
    check("pp_mod_switch", 288'({got_mod[base+287], got_mod[base+288]}), 288'(4'b1100));

    // Reset while a symbol is half written.
    send(2, rand_sym(), 21);
    rst_n = 1'b0;
    #1;
    check("rst1_outputs", 288'({out_valid, out_bit, out_last, out_mod}), 288'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst1_in_ready", 288'(in_ready), 288'(1));
    run_sym("rst1_next", 2, rand_sym(), 1'b0, base);

    // Reset while k = 50 of a symbol is on the output.
    base = got_bit.size();
    send(3, rand_sym(), 48);
    collect(base + 50, 1'b0);
    check("rst2_pre_valid", 288'(out_valid), 288'(1));
    rst_n = 1'b0;
    #1;
    check("rst2_outputs", 288'({out_valid, out_bit, out_last, out_mod}), 288'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst2_no_stale", 288'(got_bit.size() - base), 288'(50));
    check("rst2_in_ready", 288'(in_ready), 288'(1));
    run_sym("rst2_next", 1, rand_sym(), 1'b1, base);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/deinterleaver.md
Name: deinterleaver

Overview:
- Sits directly downstream of the demapper in the 802.11a receive chain and upstream of the depuncturer/Viterbi decoder.
- Collects one OFDM symbol of demapped coded bits: 48 data subcarriers, N_BPSC bits each.
- Applies the 802.11a two-permutation deinterleave and emits the bits serially in coded order with a valid/ready handshake.
- A ping-pong buffer lets one symbol fill while the previous symbol drains.

Parameters:
- N_SC, 48: data subcarriers per OFDM symbol; only 48 is supported.
- MAX_BPSC, 6: maximum bits per subcarrier; sets bank width to N_SC*MAX_BPSC = 288 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bits holds one subcarrier's demapped bits.
- in_ready  out  1  block can accept a subcarrier this cycle.
- in_bits  in  6  demapped bits; bit 0 is the earliest coded bit (I MSB side); bits above N_BPSC-1 are ignored.
- mod  in  2  modulation encoding: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled only with subcarrier 0 of each symbol.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  deinterleaved coded bit.
- out_mod  out  2  modulation of the symbol currently draining.
- out_last  out  1  marks bit k = N_CBPS-1 of the symbol.

Behaviour:
- N_BPSC per mod: 1, 2, 4, 6. N_CBPS = 48*N_BPSC, giving 48/96/192/288. s = max(N_BPSC/2, 1).
- Transfers: an input transfer occurs on in_valid & in_ready; an output transfer on out_valid & out_ready.
- Write side:
  - Write pointer selects bank 0/1; a subcarrier counter c runs 0..47.
  - The transfer of subcarrier c writes in_bits[b] to bank position j = c*N_BPSC + b, for b < N_BPSC.
  - At c = 0, mod is latched into the bank's mod register.
  - At c = 47, the bank's full flag is set, c wraps to 0, and the write pointer toggles.
  - in_ready = !full[write bank], driven from registers only.
- Read side:
  - Read pointer selects a bank; output index k runs 0..N_CBPS-1.
  - For output index k: i = (N_CBPS/16)*(k mod 16) + floor(k/16); j = s*floor(i/s) + (i + N_CBPS - floor(16*i/N_CBPS)) mod s; out_bit = bank[j].
  - out_bit, out_valid, out_mod and out_last are registered.
  - If edge E sets full, out_valid rises at E+1 with k = 0. This gives a one-cycle bubble; no combinational path from in_* to out_*.
  - While out_valid & !out_ready, all outputs hold stable.
  - On the transfer of k = N_CBPS-1 (out_last = 1): the bank's full flag clears and the read pointer toggles.
  - If the other bank is already full, the next symbol's k = 0 is presented on that same edge, so there is no bubble between symbols.
- Freed bank timing: a bank freed at edge E is writable from E+1, because in_ready is registered. Write and free never occur on the same bank at the same edge.
- Both banks full: in_ready = 0 and input stalls until a drain completes.
- Reset (asynchronous, any time, including mid-symbol):
  - Counters, pointers and full flags clear; both bank mod registers go to 0.
  - out_valid = 0, out_bit = 0, out_last = 0, out_mod = 0; in_ready rises to 1 after reset deasserts.
  - A partially written or partially read symbol is discarded.
  - Bank data storage has no reset.
- mod changing between symbols is legal; each bank uses its own latched mod.

Decomposition:
- Shared package (phy_pkg), holding:
  - MOD_BPSK/QPSK/QAM16/QAM64 encodings.
  - N_SC = 48.
  - Functions or constant tables for n_bpsc(mod), n_cbps(mod) and s(mod).
  - These same mod encodings are used by the demapper.
- Sub-module deint_addr_gen: combinational (mod, k) -> j.
  - All divisions are by 3, 6, 12 or 18 on values below 288.
  - Implement with comparisons or a case, not generic dividers.
- The top level holds the banks, the counters and the handshake logic.

Test Plan:
- BPSK, one-hot input bit j = 3 (subcarrier 3 bit 0 = 1, all others 0) -> out_bit = 1 only at k = 1; separately, j = 1 -> out_bit = 1 only at k = 16; out_last only at k = 47; out_mod = 0.
- QPSK, one-hot j = 6 (subcarrier 3 bit 0) -> 1 only at k = 1; 96 output bits total.
- 16-QAM: one-hot j = 13 (subcarrier 3 bit 1) -> 1 only at k = 1; one-hot j = 0 -> 1 only at k = 0; 192 bits total.
- 64-QAM: one-hot j = 20 (subcarrier 3 bit 2) -> 1 only at k = 1. Full random symbol output must match a reference model for all 288 bits.
- Ping-pong and backpressure, two back-to-back symbols (64-QAM then BPSK):
  - Hold out_ready low for the first 100 cycles -> third symbol sees in_ready = 0 after both banks fill.
  - out_bit is stable while stalled; symbol 2 follows symbol 1 with no bubble.
  - out_mod switches 3 -> 0 at symbol 2, k = 0.
- Reset mid-symbol: assert rst_n = 0 after subcarrier 20 of a symbol and at k = 50 of a draining symbol -> outputs go to 0 immediately; after release in_ready = 1, no stale bits are emitted, and the next full symbol deinterleaves correctly.
